// File: rtl/biquad_scheduler_pkg.sv
// Shared types and constants for the biquad scheduler slice.
package biquad_scheduler_pkg;

  localparam int unsigned CHANNEL_COUNT       = 120;
  localparam int unsigned CHANNEL_WIDTH       = 7;
  localparam int unsigned DATA_WIDTH          = 16;
  localparam int unsigned DP_LATENCY_DEFAULT  = 3;
  localparam int unsigned FRAME_WIDTH_DEFAULT = 16;

  typedef logic signed [DATA_WIDTH-1:0] data_t;
  typedef logic [CHANNEL_WIDTH-1:0]     channel_t;

  // Per-channel filter state, w1 in the upper half.
  typedef struct packed {
    data_t w1;
    data_t w2;
  } biquad_state_t;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    READ,
    ISSUE,
    WAIT,
    WRITE
  } sched_state_t;

  localparam channel_t LAST_CHANNEL = channel_t'(CHANNEL_COUNT - 1);

  // Round-robin successor; CHANNEL_COUNT is not a power of two, so wrap by compare.
  function automatic channel_t next_channel(input channel_t ch);
    return (ch == LAST_CHANNEL) ? '0 : channel_t'(ch + 1'b1);
  endfunction

endpackage

// File: rtl/biquad_scheduler_if.sv
// Sample stream, state RAM and datapath signals of the biquad scheduler.
interface biquad_scheduler_if;
  import biquad_scheduler_pkg::*;

  // Input sample stream
  logic          in_valid;
  logic          in_ready;
  data_t         in_data;
  channel_t      in_channel;
  // State RAM ports
  logic          st_rd_en;
  channel_t      st_rd_addr;
  biquad_state_t st_rd_data;
  logic          st_wr_en;
  channel_t      st_wr_addr;
  biquad_state_t st_wr_data;
  // Shared datapath
  logic          dp_valid;
  data_t         dp_x;
  biquad_state_t dp_st;
  logic          dp_done;
  data_t         dp_y;
  biquad_state_t dp_st_n;
  // Filtered output stream
  logic          out_valid;
  logic          out_ready;
  data_t         out_data;
  channel_t      out_channel;
  logic          out_last;

  // Scheduler side
  modport master (
    input  in_valid, in_data, in_channel,
    output in_ready,
    output st_rd_en, st_rd_addr,
    input  st_rd_data,
    output st_wr_en, st_wr_addr, st_wr_data,
    output dp_valid, dp_x, dp_st,
    input  dp_done, dp_y, dp_st_n,
    output out_valid, out_data, out_channel, out_last,
    input  out_ready
  );

  // Environment side: sample source, state RAM, datapath and sink
  modport slave (
    output in_valid, in_data, in_channel,
    input  in_ready,
    input  st_rd_en, st_rd_addr,
    output st_rd_data,
    input  st_wr_en, st_wr_addr, st_wr_data,
    input  dp_valid, dp_x, dp_st,
    output dp_done, dp_y, dp_st_n,
    input  out_valid, out_data, out_channel, out_last,
    output out_ready
  );

endinterface

// File: rtl/biquad_scheduler_state_clear_sweep.sv
// Address counter that walks every channel once to clear the state RAM after reset.
// Only built when BIQUAD_STATE_CLEAR_EN is defined.
`ifdef BIQUAD_STATE_CLEAR_EN
module biquad_scheduler_state_clear_sweep
  import biquad_scheduler_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     en_i,
  output channel_t addr_o,
  output logic     last_o,
  output logic     done_o
);

  channel_t addr_q;
  logic     done_q;

  // Advance one address per enabled cycle; latch done after the last channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      done_q <= 1'b0;
    end else if (en_i && !done_q) begin
      if (addr_q == LAST_CHANNEL) begin
        done_q <= 1'b1;
      end else begin
        addr_q <= channel_t'(addr_q + 1'b1);
      end
    end
  end

  assign addr_o = addr_q;
  assign last_o = (addr_q == LAST_CHANNEL);
  assign done_o = done_q;

endmodule
`endif

// File: rtl/biquad_scheduler.sv
// Time-multiplexes one biquad datapath across all channels: read state, issue,
// wait for the result, write state back and forward the filtered sample.
// Optional post-reset state RAM clear: define BIQUAD_STATE_CLEAR_EN.
module biquad_scheduler
  import biquad_scheduler_pkg::*;
#(
  parameter int unsigned DP_LATENCY  = DP_LATENCY_DEFAULT,
  parameter int unsigned FRAME_WIDTH = FRAME_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  biquad_scheduler_if.master     bus,
  output logic [FRAME_WIDTH-1:0] frame_cnt,
  output logic                   seq_err
);

  // The scheduler waits on dp_done, so the latency only needs to be in range.
  if ((DP_LATENCY == 0) || (DP_LATENCY > 15)) begin : g_bad_latency
    $error("biquad_scheduler: DP_LATENCY must be 1..15");
  end

  sched_state_t           state_q;
  logic                   in_ready_q;
  logic                   st_rd_en_q;
  channel_t               st_rd_addr_q;
  logic                   st_wr_en_q;
  channel_t               st_wr_addr_q;
  biquad_state_t          st_wr_data_q;
  logic                   dp_valid_q;
  data_t                  data_q;
  channel_t               chan_q;
  logic                   out_valid_q;
  data_t                  out_data_q;
  channel_t               out_channel_q;
  logic                   out_last_q;
  channel_t               exp_ch_q;
  logic [FRAME_WIDTH-1:0] frame_cnt_q;
  logic                   seq_err_q;

`ifdef BIQUAD_STATE_CLEAR_EN
  localparam sched_state_t RESET_STATE = INIT;

  channel_t sweep_addr;
  logic     sweep_last;
  logic     sweep_done;

  biquad_scheduler_state_clear_sweep u_sweep (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   ((state_q == INIT) && !sweep_done),
    .addr_o (sweep_addr),
    .last_o (sweep_last),
    .done_o (sweep_done)
  );
`else
  localparam sched_state_t RESET_STATE = IDLE;
`endif

  // Scheduler FSM with registered strobes, output stream and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      in_ready_q    <= 1'b0;
      st_rd_en_q    <= 1'b0;
      st_rd_addr_q  <= '0;
      st_wr_en_q    <= 1'b0;
      st_wr_addr_q  <= '0;
      st_wr_data_q  <= '0;
      dp_valid_q    <= 1'b0;
      data_q        <= '0;
      chan_q        <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      out_last_q    <= 1'b0;
      exp_ch_q      <= '0;
      frame_cnt_q   <= '0;
      seq_err_q     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless a state re-asserts them.
      st_rd_en_q <= 1'b0;
      st_wr_en_q <= 1'b0;
      dp_valid_q <= 1'b0;

      unique case (state_q)
        INIT: begin
`ifdef BIQUAD_STATE_CLEAR_EN
          st_wr_en_q   <= 1'b1;
          st_wr_addr_q <= sweep_addr;
          st_wr_data_q <= '0;
          if (sweep_last) begin
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
`else
          state_q <= IDLE;
`endif
        end

        IDLE: begin
          if (in_ready_q && bus.in_valid) begin
            in_ready_q   <= 1'b0;
            data_q       <= bus.in_data;
            chan_q       <= bus.in_channel;
            st_rd_en_q   <= 1'b1;
            st_rd_addr_q <= bus.in_channel;
            exp_ch_q     <= next_channel(bus.in_channel);
            if (bus.in_channel != exp_ch_q) begin
              seq_err_q <= 1'b1;
            end
            state_q <= READ;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        READ: begin
          dp_valid_q <= 1'b1;
          state_q    <= ISSUE;
        end

        ISSUE: begin
          state_q <= WAIT;
        end

        WAIT: begin
          if (bus.dp_done) begin
            st_wr_en_q    <= 1'b1;
            st_wr_addr_q  <= chan_q;
            st_wr_data_q  <= bus.dp_st_n;
            out_valid_q   <= 1'b1;
            out_data_q    <= bus.dp_y;
            out_channel_q <= chan_q;
            out_last_q    <= (chan_q == LAST_CHANNEL);
            state_q       <= WRITE;
          end
        end

        WRITE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            if (out_last_q) begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.st_rd_en    = st_rd_en_q;
  assign bus.st_rd_addr  = st_rd_addr_q;
  assign bus.st_wr_en    = st_wr_en_q;
  assign bus.st_wr_addr  = st_wr_addr_q;
  assign bus.st_wr_data  = st_wr_data_q;
  assign bus.dp_valid    = dp_valid_q;
  assign bus.dp_x        = data_q;
  // RAM read data arrives in the issue cycle itself, so it is forwarded directly.
  assign bus.dp_st       = bus.st_rd_data;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
  assign bus.out_last    = out_last_q;
  assign frame_cnt       = frame_cnt_q;
  assign seq_err         = seq_err_q;

endmodule

// File: tb/tb_biquad_scheduler.sv
// Directed bench for biquad_scheduler with a state RAM model and a fixed-latency datapath model.
module tb_biquad_scheduler;
  import biquad_scheduler_pkg::*;

  localparam int L = 3;

`ifdef BIQUAD_STATE_CLEAR_EN
  localparam int INIT_WRITES = 120;
  localparam int TOUCH0      = 0;
  localparam int TOUCH1      = 0;
  localparam int TOUCH4      = 0;
`else
  localparam int INIT_WRITES = 0;
  localparam int TOUCH0      = 2;
  localparam int TOUCH1      = 1;
  localparam int TOUCH4      = 1;
`endif

  typedef struct {
    int ch;
    int d;
    int y;
    int hold;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] frame_cnt;
  logic        seq_err;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int hs_cnt = 0;

  always #5 clk = ~clk;

  biquad_scheduler_if bus ();

  biquad_scheduler #(
    .DP_LATENCY  (L),
    .FRAME_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .seq_err   (seq_err)
  );

  // State RAM model: one-cycle read latency, counts writes and output handshakes.
  biquad_state_t ram [CHANNEL_COUNT] = '{default: '0};
  biquad_state_t rd_q = '0;
  always @(posedge clk) begin
    if (bus.st_rd_en) rd_q <= ram[bus.st_rd_addr];
    if (bus.st_wr_en) begin
      ram[bus.st_wr_addr] <= bus.st_wr_data;
      wr_cnt <= wr_cnt + 1;
    end
    if (bus.out_valid && bus.out_ready) hs_cnt <= hs_cnt + 1;
  end
  assign bus.st_rd_data = rd_q;

  // Datapath model: y = x/2 (floor), state += {7, 8}; done L cycles after issue, never reset.
  logic [L-1:0]  pv = '0;
  data_t         py [L];
  biquad_state_t ps [L];
  always @(posedge clk) begin
    pv[0] <= bus.dp_valid;
    py[0] <= bus.dp_x >>> 1;
    ps[0] <= '{w1: data_t'(bus.dp_st.w1 + 16'sd7), w2: data_t'(bus.dp_st.w2 + 16'sd8)};
    for (int i = 1; i < L; i++) begin
      pv[i] <= pv[i-1];
      py[i] <= py[i-1];
      ps[i] <= ps[i-1];
    end
  end
  assign bus.dp_done = pv[L-1];
  assign bus.dp_y    = py[L-1];
  assign bus.dp_st_n = ps[L-1];

  task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},    bus.in_ready, 0);
    check({tag, "_st_rd_en"},    bus.st_rd_en, 0);
    check({tag, "_st_wr_en"},    bus.st_wr_en, 0);
    check({tag, "_dp_valid"},    bus.dp_valid, 0);
    check({tag, "_out_valid"},   bus.out_valid, 0);
    check({tag, "_out_data"},    bus.out_data, 0);
    check({tag, "_out_channel"}, bus.out_channel, 0);
    check({tag, "_out_last"},    bus.out_last, 0);
    check({tag, "_frame_cnt"},   frame_cnt, 0);
    check({tag, "_seq_err"},     seq_err, 0);
  endtask

  // Called just after reset release; returns #1 after the edge where in_ready rises.
  task automatic check_init();
`ifdef BIQUAD_STATE_CLEAR_EN
    int n = 0;
    int idx = 0;
    @(posedge clk); #1;
    while (!bus.in_ready && n < 300) begin
      if (bus.st_wr_en) begin
        check($sformatf("init_addr%0d", idx), bus.st_wr_addr, idx);
        check($sformatf("init_data%0d", idx), bus.st_wr_data, 0);
        idx++;
      end
      @(posedge clk); #1;
      n++;
    end
    check("init_write_count", idx, 120);
    check("init_ready", bus.in_ready, 1);
    check("init_wr_done", bus.st_wr_en, 0);
`else
    @(posedge clk); #1;
    check("ready_after_reset", bus.in_ready, 1);
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_ready_timeout", bus.in_ready, 1);
  endtask

  // One sample through the scheduler with per-cycle timing checks.
  task automatic send(input int ch, input int d, input int y, input int hold,
                      input int w1, input int w2, input int exp_seq, input int exp_frame);
    int n;
    int wr0;
    wait_ready();
    bus.out_ready  = (hold == 0);
    bus.in_valid   = 1'b1;
    bus.in_channel = channel_t'(ch);
    bus.in_data    = data_t'(d);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check($sformatf("ch%0d_rd_en", ch),   bus.st_rd_en, 1);
    check($sformatf("ch%0d_rd_addr", ch), bus.st_rd_addr, ch);
    check($sformatf("ch%0d_busy", ch),    bus.in_ready, 0);
    @(posedge clk); #1;
    check($sformatf("ch%0d_dp_valid", ch), bus.dp_valid, 1);
    check($sformatf("ch%0d_dp_x", ch),     bus.dp_x, d);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    wr0 = wr_cnt;
    check($sformatf("ch%0d_latency", ch),  n, L + 1);
    check($sformatf("ch%0d_wr_en", ch),    bus.st_wr_en, 1);
    check($sformatf("ch%0d_wr_addr", ch),  bus.st_wr_addr, ch);
    check($sformatf("ch%0d_wr_w1", ch),    bus.st_wr_data.w1, w1);
    check($sformatf("ch%0d_wr_w2", ch),    bus.st_wr_data.w2, w2);
    check($sformatf("ch%0d_out_data", ch), bus.out_data, y);
    check($sformatf("ch%0d_out_ch", ch),   bus.out_channel, ch);
    check($sformatf("ch%0d_out_last", ch), bus.out_last, (ch == 119) ? 1 : 0);
    check($sformatf("ch%0d_seq_err", ch),  seq_err, exp_seq);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check($sformatf("ch%0d_stall%0d_valid", ch, k), bus.out_valid, 1);
      check($sformatf("ch%0d_stall%0d_data", ch, k),  bus.out_data, y);
      check($sformatf("ch%0d_stall%0d_ch", ch, k),    bus.out_channel, ch);
      check($sformatf("ch%0d_stall%0d_wr", ch, k),    bus.st_wr_en, 0);
      check($sformatf("ch%0d_stall%0d_ready", ch, k), bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check($sformatf("ch%0d_out_done", ch),  bus.out_valid, 0);
    check($sformatf("ch%0d_ready_back", ch), bus.in_ready, 1);
    check($sformatf("ch%0d_one_write", ch), wr_cnt - wr0, 1);
    check($sformatf("ch%0d_frame_cnt", ch), frame_cnt, exp_frame);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [5];
    int   d;
    int   wr0;
    int   hs0;

    vecs[0] = '{ch: 0, d: 100,    y: 50,     hold: 0};
    vecs[1] = '{ch: 1, d: -40,    y: -20,    hold: 10};
    vecs[2] = '{ch: 2, d: 3,      y: 1,      hold: 0};
    vecs[3] = '{ch: 3, d: -3,     y: -2,     hold: 0};
    vecs[4] = '{ch: 4, d: -32768, y: -16384, hold: 0};

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_channel = '0;
    bus.out_ready  = 1'b1;
    rst_n          = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset("por");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    check_init();

    // First-touch vectors: every channel starts from state {0,0}.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].ch, vecs[i].d, vecs[i].y, vecs[i].hold, 7, 8, 0, 0);
    end

    // Rest of the first frame in order.
    for (int ch = 5; ch < 120; ch++) begin
      d = ch * 37 - 2000;
      send(ch, d, d >>> 1, 0, 7, 8, 0, (ch == 119) ? 1 : 0);
    end

    // Order error: 0 then 2, then correct 3; flag is sticky.
    send(0, 10, 5,  0, 14, 16, 0, 1);
    send(2, 20, 10, 0, 14, 16, 1, 1);
    send(3, 30, 15, 0, 14, 16, 1, 1);

    // Reset while the datapath is busy; its late dp_done must be ignored.
    wait_ready();
    bus.in_valid   = 1'b1;
    bus.in_channel = channel_t'(4);
    bus.in_data    = data_t'(50);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1 check_reset("mid_wait");
    wr0 = wr_cnt;
    hs0 = hs_cnt;
    @(negedge clk) rst_n = 1'b1;
    check_init();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("late_done_valid%0d", k), bus.out_valid, 0);
      check($sformatf("late_done_wr%0d", k),    bus.st_wr_en, 0);
    end
    check("late_done_writes", wr_cnt, wr0 + INIT_WRITES);
    check("late_done_hs", hs_cnt, hs0);
    check("lost_ch4_w1", ram[4].w1, 7 * TOUCH4);
    check("lost_ch4_w2", ram[4].w2, 8 * TOUCH4);

    // Traffic after reset: expected channel back to 0, counters cleared.
    send(0, 8,  4,  0, 7 * (TOUCH0 + 1), 8 * (TOUCH0 + 1), 0, 0);
    send(1, -8, -4, 0, 7 * (TOUCH1 + 1), 8 * (TOUCH1 + 1), 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
